// File: rtl/i_fetch_pkg.sv
// rtl/i_fetch_pkg.sv - shared fetch states, widths and instruction byte constants for bfcpu
package i_fetch_pkg;

  // Default instruction address width
  localparam int DEF_ADDR_WIDTH = 16;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } fetch_state_e;

  // Instruction bytes as seen by decode
  localparam logic [7:0] OP_INC        = 8'h2B;  // '+'
  localparam logic [7:0] OP_DEC        = 8'h2D;  // '-'
  localparam logic [7:0] OP_RIGHT      = 8'h3E;  // '>'
  localparam logic [7:0] OP_LEFT       = 8'h3C;  // '<'
  localparam logic [7:0] OP_OUT        = 8'h2E;  // '.'
  localparam logic [7:0] OP_IN         = 8'h2C;  // ','
  localparam logic [7:0] OP_LOOP_OPEN  = 8'h5B;  // '['
  localparam logic [7:0] OP_LOOP_CLOSE = 8'h5D;  // ']'

endpackage

// File: rtl/i_fetch_buf.sv
// rtl/i_fetch_buf.sv - two-entry {pc,data} prefetch FIFO with flush
module i_fetch_buf #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [AW-1:0] push_pc_i,
  input  logic [7:0]    push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [1:0]    count_o,
  output logic [AW-1:0] head_pc_o,
  output logic [7:0]    head_data_o
);

  logic [1:0]    count_q, count_d;
  logic [AW-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [7:0]    dat0_q, dat0_d, dat1_q, dat1_d;
  logic          do_pop, do_push;

  // Entry 0 is always the head; a pop shifts entry 1 down into it
  always_comb begin
    count_d = count_q;
    pc0_d   = pc0_q;
    dat0_d  = dat0_q;
    pc1_d   = pc1_q;
    dat1_d  = dat1_q;
    do_pop  = pop_i && (count_q != 2'd0);
    do_push = push_i && ((count_q != 2'd2) || do_pop);
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            pc0_d  = push_pc_i;
            dat0_d = push_data_i;
          end else begin
            pc1_d  = push_pc_i;
            dat1_d = push_data_i;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          pc0_d   = pc1_q;
          dat0_d  = dat1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            pc0_d  = push_pc_i;
            dat0_d = push_data_i;
          end else begin
            pc0_d  = pc1_q;
            dat0_d = dat1_q;
            pc1_d  = push_pc_i;
            dat1_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      pc0_q   <= '0;
      dat0_q  <= 8'd0;
      pc1_q   <= '0;
      dat1_q  <= 8'd0;
    end else begin
      count_q <= count_d;
      pc0_q   <= pc0_d;
      dat0_q  <= dat0_d;
      pc1_q   <= pc1_d;
      dat1_q  <= dat1_d;
    end
  end

  assign count_o     = count_q;
  assign head_pc_o   = pc0_q;
  assign head_data_o = dat0_q;

endmodule

// File: rtl/i_fetch.sv
// rtl/i_fetch.sv - bfcpu instruction fetch: request sequencer, prefetch buffer, redirect and end detect
module i_fetch
  import i_fetch_pkg::*;
#(
  parameter int I_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int I_MEM_LENGTH = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    i_req,
  output logic [I_ADDR_WIDTH-1:0] i_addr,
  input  logic                    i_ack,
  input  logic [7:0]              i_rdata,
  output logic                    f_valid,
  output logic [7:0]              f_data,
  output logic [I_ADDR_WIDTH-1:0] f_pc,
  input  logic                    f_ready,
  input  logic                    f_redirect,
  input  logic [I_ADDR_WIDTH-1:0] f_target,
  output logic                    f_end
);

  // One extra PC bit so a memory of exactly 2^I_ADDR_WIDTH bytes can be run past
  localparam int              PW      = I_ADDR_WIDTH + 1;
  localparam logic [PW-1:0]   MEM_LEN = PW'(I_MEM_LENGTH);
  localparam logic [PW-1:0]   PC_ONE  = PW'(1);

  fetch_state_e  state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  logic [1:0]    count;
  logic          has_room, in_range, ack_take, pop_take;

  // Only one request is ever outstanding, so count<2 at issue leaves a slot for its data
  assign has_room = (count < 2'd2);
  assign in_range = (pc_q < MEM_LEN);
  assign ack_take = (state_q == ST_REQ) && i_ack && !f_redirect;
  assign pop_take = f_valid && f_ready && !f_redirect;

  // Next state, next PC and request output; redirect overrides everything
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    i_req   = (state_q == ST_REQ);
    if (f_redirect) begin
      state_d = ST_GAP;
      pc_d    = {1'b0, f_target};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (has_room && in_range) state_d = ST_REQ;
        end
        ST_REQ: begin
          if (i_ack) begin
            pc_d    = pc_q + PC_ONE;
            state_d = ST_GAP;
          end
        end
        ST_GAP: begin
          state_d = (has_room && in_range) ? ST_REQ : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer state and fetch PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  i_fetch_buf #(
    .AW (I_ADDR_WIDTH)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (ack_take),
    .push_pc_i   (pc_q[I_ADDR_WIDTH-1:0]),
    .push_data_i (i_rdata),
    .pop_i       (pop_take),
    .flush_i     (f_redirect),
    .count_o     (count),
    .head_pc_o   (f_pc),
    .head_data_o (f_data)
  );

  assign i_addr  = pc_q[I_ADDR_WIDTH-1:0];
  assign f_valid = (count != 2'd0);
  assign f_end   = !in_range && (count == 2'd0) && (state_q != ST_REQ);

endmodule

// File: tb/tb_i_fetch.sv
// tb/tb_i_fetch.sv - self-checking bench for i_fetch against a stream-level reference model
module tb_i_fetch;

  localparam int AW   = 16;
  localparam int LEN0 = 1024;
  localparam int LEN1 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]         req, ack, fv, rdy, redir, fend;
  logic [1:0][AW-1:0] addr, fpc, tgt;
  logic [1:0][7:0]    rdata, fd;

  always #5 clk = ~clk;

  i_fetch #(.I_ADDR_WIDTH(AW), .I_MEM_LENGTH(LEN0)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_req(req[0]), .i_addr(addr[0]), .i_ack(ack[0]),
    .i_rdata(rdata[0]), .f_valid(fv[0]), .f_data(fd[0]), .f_pc(fpc[0]),
    .f_ready(rdy[0]), .f_redirect(redir[0]), .f_target(tgt[0]), .f_end(fend[0])
  );

  i_fetch #(.I_ADDR_WIDTH(AW), .I_MEM_LENGTH(LEN1)) u_dut_short (
    .clk(clk), .rst_n(rst_n), .i_req(req[1]), .i_addr(addr[1]), .i_ack(ack[1]),
    .i_rdata(rdata[1]), .f_valid(fv[1]), .f_data(fd[1]), .f_pc(fpc[1]),
    .f_ready(rdy[1]), .f_redirect(redir[1]), .f_target(tgt[1]), .f_end(fend[1])
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_lat = 1;

  logic [1:0]         p_rdy = '0;
  logic [1:0]         p_redir = '0;
  logic [1:0][AW-1:0] p_tgt = '0;
  int redir_on_ack_addr = -1;
  int redir_cyc = -1;

  // reference model: fetch PC and buffered PCs per instance
  int unsigned m_pc [2];
  int          m_qn [2];
  int unsigned m_q  [2][2];
  int          idle_run [2];
  int          reqc [2];
  logic        prev_req [2];
  logic        prev_acked [2];
  logic [AW-1:0] prev_addr [2];

  // observation logs for instance 0
  int unsigned fetch_log [$];
  int unsigned pop_pc_log [$];
  int unsigned pop_dat_log [$];
  int          pop_cyc_log [$];
  int first_req_cyc, first_ack_cyc, first_fv_cyc;

  function automatic logic [7:0] mem_byte(input int unsigned a);
    case (a)
      0: return 8'h2B;
      1: return 8'h3E;
      2: return 8'h5B;
      3: return 8'h5D;
      default: return 8'((a * 37) + 11);
    endcase
  endfunction

  function automatic int unsigned len_of(input int k);
    return (k == 0) ? LEN0 : LEN1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic reset_model(input int lat);
    ack_lat = lat;
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_qn[k] = 0; idle_run[k] = 0; reqc[k] = 0;
      prev_req[k] = 1'b0; prev_acked[k] = 1'b0; prev_addr[k] = '0;
    end
    fetch_log.delete(); pop_pc_log.delete(); pop_dat_log.delete(); pop_cyc_log.delete();
    first_req_cyc = -1; first_ack_cyc = -1; first_fv_cyc = -1;
    redir_cyc = -1; redir_on_ack_addr = -1;
  endtask

  task automatic hold_reset_checks();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst%0d_i_req", k), 32'(req[k]), 32'd0);
      check_eq($sformatf("rst%0d_i_addr", k), 32'(addr[k]), 32'd0);
      check_eq($sformatf("rst%0d_f_valid", k), 32'(fv[k]), 32'd0);
      check_eq($sformatf("rst%0d_f_data", k), 32'(fd[k]), 32'd0);
      check_eq($sformatf("rst%0d_f_pc", k), 32'(fpc[k]), 32'd0);
      check_eq($sformatf("rst%0d_f_end", k), 32'(fend[k]), 32'd0);
    end
  endtask

  // release at a negedge; that cycle is cycle 0
  task automatic release_reset(input int lat);
    reset_model(lat);
    rst_n = 1'b1;
    ack = '0; redir = '0; p_redir = '0;
    rdy = p_rdy; tgt = p_tgt;
    rdata = '0;
    cyc = 0;
  endtask

  task automatic do_reset(input int lat);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    hold_reset_checks();
    @(negedge clk);
    release_reset(lat);
  endtask

  task automatic model_cycle(input int k);
    int unsigned len;
    logic elig;
    len = len_of(k);
    check_eq($sformatf("i%0d_f_valid", k), 32'(fv[k]), 32'(m_qn[k] != 0));
    if (m_qn[k] != 0) begin
      check_eq($sformatf("i%0d_f_pc", k), 32'(fpc[k]), 32'(AW'(m_q[k][0])));
      check_eq($sformatf("i%0d_f_data", k), 32'(fd[k]), 32'(mem_byte(m_q[k][0])));
    end
    check_eq($sformatf("i%0d_f_end", k), 32'(fend[k]),
             32'((m_pc[k] >= len) && (m_qn[k] == 0) && !req[k]));
    if (req[k]) begin
      check_eq($sformatf("i%0d_i_addr", k), 32'(addr[k]), 32'(AW'(m_pc[k])));
      check_eq($sformatf("i%0d_req_in_range", k), 32'(m_pc[k] < len), 32'd1);
      check_eq($sformatf("i%0d_req_has_room", k), 32'(m_qn[k] < 2), 32'd1);
    end
    if (prev_acked[k]) check_eq($sformatf("i%0d_req_gap_after_ack", k), 32'(req[k]), 32'd0);
    if (req[k] && prev_req[k]) check_eq($sformatf("i%0d_addr_stable", k), 32'(addr[k]), 32'(prev_addr[k]));
    elig = (m_pc[k] < len) && (m_qn[k] < 2) && !req[k];
    idle_run[k] = elig ? idle_run[k] + 1 : 0;
    check_eq($sformatf("i%0d_issue_lag", k), 32'(idle_run[k] <= 1), 32'd1);

    if (k == 0) begin
      if (req[0] && first_req_cyc < 0) first_req_cyc = cyc;
      if (req[0] && ack[0] && first_ack_cyc < 0) first_ack_cyc = cyc;
      if (fv[0] && first_fv_cyc < 0) first_fv_cyc = cyc;
    end
    prev_req[k] = req[k];
    prev_addr[k] = addr[k];
    prev_acked[k] = req[k] && ack[k];

    if (redir[k]) begin
      m_qn[k] = 0;
      m_pc[k] = 32'(tgt[k]);
      idle_run[k] = 0;
    end else begin
      if (m_qn[k] != 0 && rdy[k]) begin
        if (k == 0) begin
          pop_pc_log.push_back(32'(fpc[0]));
          pop_dat_log.push_back(32'(fd[0]));
          pop_cyc_log.push_back(cyc);
        end
        m_q[k][0] = m_q[k][1];
        m_qn[k]--;
      end
      if (req[k] && ack[k]) begin
        if (k == 0) fetch_log.push_back(m_pc[k]);
        if (m_qn[k] < 2) begin
          m_q[k][m_qn[k]] = m_pc[k];
          m_qn[k]++;
        end else begin
          check_eq($sformatf("i%0d_push_overflow", k), 32'(m_qn[k]), 32'd1);
        end
        m_pc[k]++;
      end
    end
  endtask

  // one clock: memory responders and controls change at the negedge, then the model steps
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (req[k]) begin
        reqc[k]++;
        ack[k] = (reqc[k] > ack_lat);
      end else begin
        reqc[k] = 0;
        ack[k] = 1'b0;
      end
      rdata[k] = ack[k] ? mem_byte(32'(addr[k])) : 8'($urandom);
      rdy[k] = p_rdy[k];
      redir[k] = p_redir[k];
      tgt[k] = p_tgt[k];
    end
    if (redir_on_ack_addr >= 0 && ack[0] && (32'(addr[0]) == redir_on_ack_addr)) begin
      redir[0] = 1'b1;
      redir_cyc = cyc;
      redir_on_ack_addr = -1;
    end
    p_redir = '0;
    for (int k = 0; k < 2; k++) model_cycle(k);
  endtask

  initial begin
    logic [7:0] exp_stream [4];
    exp_stream[0] = 8'h2B; exp_stream[1] = 8'h3E; exp_stream[2] = 8'h5B; exp_stream[3] = 8'h5D;
    ack = '0; redir = '0; rdy = '0; tgt = '0; rdata = '0;
    reset_model(1);

    // latency and steady stream with the consumer always ready
    p_rdy = 2'b11;
    do_reset(1);
    repeat (20) step();
    check_eq("lat_first_req", 32'(first_req_cyc), 32'd1);
    check_eq("lat_first_ack", 32'(first_ack_cyc), 32'd2);
    check_eq("lat_first_valid", 32'(first_fv_cyc), 32'd3);
    check_eq("stream_pops", 32'(pop_pc_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < pop_pc_log.size()) begin
        check_eq($sformatf("stream_pc%0d", i), pop_pc_log[i], 32'(i));
        check_eq($sformatf("stream_data%0d", i), pop_dat_log[i], 32'(exp_stream[i]));
        check_eq($sformatf("stream_cycle%0d", i), 32'(pop_cyc_log[i]), 32'(3 + 3 * i));
      end
    end
    check_eq("short_end_set", 32'(fend[1]), 32'd1);
    check_eq("short_end_noreq", 32'(req[1]), 32'd0);
    p_tgt[1] = '0; p_redir[1] = 1'b1;
    step();
    step();
    check_eq("short_end_cleared", 32'(fend[1]), 32'd0);
    repeat (16) step();
    check_eq("short_end_again", 32'(fend[1]), 32'd1);
    p_tgt[1] = AW'(6); p_redir[1] = 1'b1;
    step();
    step();
    check_eq("short_end_far_target", 32'(fend[1]), 32'd1);

    // backpressure: two fetches, then one pop allows exactly one more
    p_rdy = 2'b10;
    do_reset(1);
    repeat (20) step();
    check_eq("stall_fetches", 32'(fetch_log.size()), 32'd2);
    check_eq("stall_req_low", 32'(req[0]), 32'd0);
    p_rdy[0] = 1'b1; step(); p_rdy[0] = 1'b0;
    repeat (20) step();
    check_eq("stall_fetches_after_pop", 32'(fetch_log.size()), 32'd3);
    if (fetch_log.size() >= 3) check_eq("stall_third_addr", fetch_log[2], 32'd2);
    check_eq("stall_pops", 32'(pop_pc_log.size()), 32'd1);

    // asynchronous reset while a request is outstanding
    p_rdy[0] = 1'b1; step(); p_rdy[0] = 1'b0;
    for (int i = 0; i < 10 && !req[0]; i++) step();
    check_eq("midrst_req_seen", 32'(req[0]), 32'd1);
    check_eq("midrst_valid_seen", 32'(fv[0]), 32'd1);
    check_eq("midrst_end_seen", 32'(fend[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_i_req", 32'(req[0]), 32'd0);
    check_eq("midrst_f_valid", 32'(fv[0]), 32'd0);
    check_eq("midrst_f_end", 32'(fend[1]), 32'd0);
    @(negedge clk);
    release_reset(1);
    repeat (4) step();
    check_eq("midrst_restart", 32'(fetch_log.size() >= 1), 32'd1);
    if (fetch_log.size() >= 1) check_eq("midrst_restart_addr", fetch_log[0], 32'd0);

    // redirect coinciding with the ack of address 1
    p_rdy = 2'b10;
    p_tgt[0] = AW'(16'h0010);
    do_reset(1);
    redir_on_ack_addr = 1;
    for (int i = 0; i < 30 && redir_cyc < 0; i++) step();
    check_eq("redir_fired", 32'(redir_cyc >= 0), 32'd1);
    step();
    check_eq("redir_valid_next", 32'(fv[0]), 32'd0);
    check_eq("redir_gap", 32'(req[0]), 32'd0);
    step();
    check_eq("redir_req", 32'(req[0]), 32'd1);
    check_eq("redir_addr", 32'(addr[0]), 32'h10);
    for (int i = 0; i < 10 && !fv[0]; i++) step();
    check_eq("redir_head_pc", 32'(fpc[0]), 32'h10);
    check_eq("redir_head_data", 32'(fd[0]), 32'(mem_byte(16)));
    check_eq("redir_fetch_log", 32'(fetch_log.size()), 32'd2);
    if (fetch_log.size() >= 2) check_eq("redir_second_fetch", fetch_log[1], 32'h10);

    // slow memory: same stream, addresses held while waiting
    p_rdy = 2'b11;
    do_reset(3);
    repeat (40) step();
    check_eq("slow_pops", 32'(pop_pc_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < pop_pc_log.size()) begin
        check_eq($sformatf("slow_pc%0d", i), pop_pc_log[i], 32'(i));
        check_eq($sformatf("slow_data%0d", i), pop_dat_log[i], 32'(exp_stream[i]));
      end
    end

    // randomized consumer, redirects and memory latency
    for (int r = 0; r < 6; r++) begin
      p_rdy = 2'b11;
      do_reset(1 + (r % 3));
      for (int c = 0; c < 400; c++) begin
        for (int k = 0; k < 2; k++) begin
          p_rdy[k] = ($urandom % 4) != 0;
          if (($urandom % 20) == 0) begin
            p_redir[k] = 1'b1;
            if (k == 1) p_tgt[1] = AW'($urandom % 8);
            else begin
              case ($urandom % 3)
                0: p_tgt[0] = AW'($urandom % LEN0);
                1: p_tgt[0] = AW'(LEN0 - 6 + ($urandom % 10));
                default: p_tgt[0] = AW'($urandom);
              endcase
            end
          end
        end
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
